// File: rtl/rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module   : rs_syndrome_calc
// Purpose  : Reed-Solomon syndrome calculator over GF(2^8), poly 0x11D,
//            alpha = 0x02. Reads an N1-byte codeword from a synchronous RAM
//            (highest-degree coefficient first), computes S_1..S_(2*DELTA)
//            with Horner's rule, streams them out one per cycle and flags
//            the all-zero (error-free) case.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - one-cycle run request, honoured only in IDLE
//            cw_rd_en/cw_addr/cw_din - codeword RAM read port (1-cycle latency)
//            syn_valid/syn_index/syn_out - syndrome stream, syn_out = S_(index+1)
//            no_error        - all syndromes zero, held until next start
//            busy, done      - activity flag and one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module rs_syndrome_calc #(
   parameter int N1     = 46,
   parameter int DELTA  = 15,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              cw_rd_en,
   output logic [ADDR_W-1:0] cw_addr,
   input  logic [7:0]        cw_din,
   output logic              syn_valid,
   output logic [4:0]        syn_index,
   output logic [7:0]        syn_out,
   output logic              no_error,
   output logic              busy,
   output logic              done
);

   localparam int                c_nsyn      = 2 * DELTA;
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N1 - 1);
   localparam logic [ADDR_W-1:0] c_last_syn  = ADDR_W'(c_nsyn - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAIN = 3'd2,
      S_OUT   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   // Multiply by x modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   // Shift-and-add multiply; with a constant operand this folds to XOR trees.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gf_xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_alpha_pow(input int e);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 0; i < e; i++) v = gf_xtime(v);
      return v;
   endfunction

   state_t            r_state;
   state_t            w_state_n;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_n;
   logic              r_data_vld;
   logic              w_accept;
   logic [7:0]        r_acc     [c_nsyn];
   logic [7:0]        w_acc_upd [c_nsyn];
   logic [c_nsyn-1:0] w_acc_nz;

   assign w_accept = (r_state == S_IDLE) && start;

   // One Horner accumulator per syndrome; index j holds S_(j+1).
   generate
      for (genvar j = 0; j < c_nsyn; j++) begin : g_acc
         localparam logic [7:0] c_alpha = gf_alpha_pow(j + 1);

         assign w_acc_upd[j] = r_data_vld ? (gf_mul(r_acc[j], c_alpha) ^ cw_din)
                                          : r_acc[j];
         assign w_acc_nz[j]  = |r_acc[j];

         always_ff @(posedge clk) begin
            if (rst || w_accept) r_acc[j] <= 8'h00;
            else                 r_acc[j] <= w_acc_upd[j];
         end
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
      end
   end

   // Next-state logic; r_cnt is the RAM address in LOAD and the syndrome
   // index in OUT.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_n = S_LOAD;
               w_cnt_n   = c_last_addr;
            end
         end
         S_LOAD: begin
            if (r_cnt == '0) w_state_n = S_DRAIN;
            else             w_cnt_n   = r_cnt - 1'b1;
         end
         S_DRAIN: begin
            w_state_n = S_OUT;
            w_cnt_n   = '0;
         end
         S_OUT: begin
            if (r_cnt == c_last_syn) begin
               w_state_n = S_FIN;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n   = r_cnt + 1'b1;
            end
         end
         S_FIN: begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
         end
         default: begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
         end
      endcase
   end

   // Output registers are loaded from the next state so each output lines up
   // with the cycle its state occupies. syn_out takes the updated accumulator
   // value so that the r_0 byte folded in during DRAIN is seen by S_1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_rd_en   <= 1'b0;
         cw_addr    <= '0;
         r_data_vld <= 1'b0;
         syn_valid  <= 1'b0;
         syn_index  <= '0;
         syn_out    <= '0;
         no_error   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_data_vld <= cw_rd_en;
         cw_rd_en   <= (w_state_n == S_LOAD);
         cw_addr    <= (w_state_n == S_LOAD) ? w_cnt_n : '0;
         syn_valid  <= (w_state_n == S_OUT);
         syn_index  <= (w_state_n == S_OUT) ? w_cnt_n[4:0] : 5'd0;
         syn_out    <= (w_state_n == S_OUT) ? w_acc_upd[w_cnt_n[4:0]] : 8'h00;
         busy       <= (w_state_n != S_IDLE);
         done       <= (w_state_n == S_FIN);
         if (w_accept)                                     no_error <= 1'b0;
         else if (r_state == S_OUT && w_state_n == S_FIN)  no_error <= ~|w_acc_nz;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_syndrome_calc
// Purpose  : Directed self-checking bench for rs_syndrome_calc with a
//            synchronous codeword RAM model (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_calc;

   localparam int N1     = 46;
   localparam int DELTA  = 15;
   localparam int ADDR_W = 6;
   localparam int NSYN   = 2 * DELTA;

   logic              clk;
   logic              rst;
   logic              start;
   logic              cw_rd_en;
   logic [ADDR_W-1:0] cw_addr;
   logic [7:0]        cw_din;
   logic              syn_valid;
   logic [4:0]        syn_index;
   logic [7:0]        syn_out;
   logic              no_error;
   logic              busy;
   logic              done;

   logic [7:0] mem [64];

   // alpha^j, j = 1..30, over 0x11D
   logic [7:0] alpha_tab [NSYN] = '{
      8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74,
      8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26, 8'h4C, 8'h98, 8'h2D, 8'h5A, 8'hB4,
      8'h75, 8'hEA, 8'hC9, 8'h8F, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60};

   int checks;
   int errors;

   // Per-run capture
   logic [7:0] syn [NSYN];
   int addr_bad;
   int idx_bad;
   int nsyn;
   int done_cyc;
   logic ne_at_done;

   rs_syndrome_calc #(.N1(N1), .DELTA(DELTA), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cw_rd_en  (cw_rd_en),
      .cw_addr   (cw_addr),
      .cw_din    (cw_din),
      .syn_valid (syn_valid),
      .syn_index (syn_index),
      .syn_out   (syn_out),
      .no_error  (no_error),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cw_rd_en) cw_din <= mem[cw_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
   endtask

   // Pulses start in the current cycle (cycle 0), then observes cycles 1..78.
   // Extra start pulses are placed in cycles p1/p2 (0 = none). Returns with
   // the bench positioned 1 time unit into cycle 79.
   task automatic run_cw(input int p1, input int p2);
      addr_bad   = 0;
      idx_bad    = 0;
      nsyn       = 0;
      done_cyc   = -1;
      ne_at_done = 1'bx;
      for (int i = 0; i < NSYN; i++) syn[i] = 8'hxx;
      start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= N1 + NSYN + 2; k++) begin
         start = (k == p1) || (k == p2);
         if (k <= N1) begin
            if (!cw_rd_en || int'(cw_addr) != N1 - k) addr_bad++;
         end else if (cw_rd_en) begin
            addr_bad++;
         end
         if (syn_valid) begin
            if (int'(syn_index) != k - (N1 + 2)) idx_bad++;
            if (syn_index < 5'(NSYN)) syn[syn_index] = syn_out;
            nsyn++;
         end
         if (done) begin
            done_cyc   = k;
            ne_at_done = no_error;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic chk_run(input string tag);
      chk({tag, "_addr_seq_errs"}, addr_bad, 0);
      chk({tag, "_index_errs"}, idx_bad, 0);
      chk({tag, "_syn_count"}, nsyn, NSYN);
      chk({tag, "_done_cycle"}, done_cyc, 78);
   endtask

   initial begin
      int bad;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      cw_din = 8'h00;
      clear_mem();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", cw_rd_en, 0);
      chk("rst_addr", cw_addr, 0);
      chk("rst_syn_valid", syn_valid, 0);
      chk("rst_no_error", no_error, 0);
      @(posedge clk); #1;

      // All-zero codeword
      run_cw(0, 0);
      chk_run("zero");
      bad = 0;
      for (int i = 0; i < NSYN; i++) if (syn[i] !== 8'h00) bad++;
      chk("zero_nonzero_syns", bad, 0);
      chk("zero_no_error", ne_at_done, 1);
      chk("zero_busy_c79", busy, 0);
      repeat (2) @(posedge clk);
      #1;

      // r_0 = 1 -> every syndrome 0x01
      clear_mem();
      mem[0] = 8'h01;
      run_cw(0, 0);
      chk_run("r0");
      bad = 0;
      for (int i = 0; i < NSYN; i++) if (syn[i] !== 8'h01) bad++;
      chk("r0_syn_not_01", bad, 0);
      chk("r0_no_error", ne_at_done, 0);
      repeat (2) @(posedge clk);
      #1;

      // r_1 = 1 -> S_j = alpha^j
      clear_mem();
      mem[1] = 8'h01;
      run_cw(0, 0);
      chk_run("r1");
      chk("r1_S1", syn[0], 8'h02);
      chk("r1_S2", syn[1], 8'h04);
      chk("r1_S8", syn[7], 8'h1D);
      chk("r1_S9", syn[8], 8'h3A);
      chk("r1_S10", syn[9], 8'h74);
      chk("r1_no_error", ne_at_done, 0);
      repeat (2) @(posedge clk);
      #1;

      // r_2 = 1 -> S_j = alpha^(2j), then back-to-back all-zero run
      clear_mem();
      mem[2] = 8'h01;
      run_cw(0, 0);
      chk_run("r2");
      chk("r2_S1", syn[0], 8'h04);
      chk("r2_S2", syn[1], 8'h10);
      chk("r2_S4", syn[3], 8'h1D);
      clear_mem();
      run_cw(0, 0);
      chk_run("b2b");
      bad = 0;
      for (int i = 0; i < NSYN; i++) if (syn[i] !== 8'h00) bad++;
      chk("b2b_nonzero_syns", bad, 0);
      chk("b2b_no_error", ne_at_done, 1);
      repeat (2) @(posedge clk);
      #1;

      // Extra start pulses during LOAD (cycle 10) and OUT (cycle 60)
      clear_mem();
      mem[1] = 8'h01;
      mem[7] = 8'h00;
      run_cw(10, 60);
      chk_run("restart");
      bad = 0;
      for (int i = 0; i < NSYN; i++) if (syn[i] !== alpha_tab[i]) bad++;
      chk("restart_syn_mismatches", bad, 0);
      chk("restart_busy_c79", busy, 0);
      repeat (2) @(posedge clk);
      #1;

      // Reset in mid-LOAD (cycle 20)
      clear_mem();
      mem[5] = 8'hA5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("midrst_busy_before", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en", cw_rd_en, 0);
      chk("midrst_syn_valid", syn_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_no_error", no_error, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_output", syn_valid | done, 0);
      clear_mem();
      mem[1] = 8'h01;
      run_cw(0, 0);
      chk_run("after_rst");
      chk("after_rst_S1", syn[0], 8'h02);
      bad = 0;
      for (int i = 0; i < NSYN; i++) if (syn[i] !== alpha_tab[i]) bad++;
      chk("after_rst_syn_mismatches", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
Computes the 2*DELTA Reed-Solomon syndromes S_j = sum_i r_i * alpha^(i*j), j = 1..2*DELTA, of a received N1-byte codeword in the HQC decapsulation path. Arithmetic is over GF(2^8) with polynomial x^8+x^4+x^3+x^2+1 (0x11D) and alpha = 0x02. The block reads the codeword from an external synchronous RAM. It streams the syndromes to the downstream key-equation solver, which runs on the gfmul datapath, and flags the error-free case.

Parameters:
N1, 46, codeword length in bytes (RS code length).
DELTA, 15, error-correcting capability; the block produces 2*DELTA syndromes.
ADDR_W, 6, codeword RAM address width; must satisfy 2^ADDR_W >= N1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin; honoured only in IDLE
cw_rd_en  output  1  codeword RAM read enable
cw_addr  output  ADDR_W  codeword RAM byte address; address i holds r_i, the coefficient of x^i
cw_din  input  8  RAM read data, valid exactly 1 cycle after cw_rd_en
syn_valid  output  1  syn_out/syn_index valid this cycle
syn_index  output  5  syndrome index k, 0..2*DELTA-1; syn_out = S_(k+1)
syn_out  output  8  syndrome value
no_error  output  1  all syndromes zero; valid when done=1, held until next start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-run):
  - state goes to IDLE and all 2*DELTA accumulators clear to 0.
  - cw_rd_en, cw_addr, syn_valid, syn_index, syn_out, no_error, busy and done all go to 0.
  - No partial result is emitted after reset.
- FSM states: IDLE, LOAD, DRAIN, OUT, FIN.
- IDLE: when start=1, clear all accumulators and go to LOAD. start in any other state is ignored with no effect.
- LOAD (N1 cycles):
  - cw_rd_en=1; cw_addr = N1-1 in the first cycle, decrementing by 1 each cycle down to 0.
  - After the cycle with address 0, go to DRAIN.
- Accumulation:
  - Uses a one-cycle-delayed copy of cw_rd_en as data-valid.
  - When data-valid is high, every accumulator j (1..2*DELTA) updates in parallel: acc_j <= gfmul_const(acc_j, alpha^j) XOR cw_din (Horner's rule, highest degree first).
  - The alpha^j constants are fixed at elaboration. The constant multiplies are combinational, with 0x11D reduction.
- DRAIN (1 cycle): cw_rd_en=0; the last byte (r_0) is accumulated. Go to OUT.
- OUT (2*DELTA cycles):
  - syn_valid=1; syn_index counts 0..2*DELTA-1, one per cycle; syn_out = acc_(syn_index+1).
  - There is no backpressure: the consumer must accept one syndrome per cycle.
  - After the last index, go to FIN.
- FIN (1 cycle): done=1; no_error=1 iff all accumulators are 0x00. Go to IDLE.
- Timing: with start sampled in cycle 0:
  - LOAD occupies cycles 1..N1.
  - DRAIN is cycle N1+1.
  - OUT occupies cycles N1+2..N1+2*DELTA+1.
  - done is high in cycle N1+2*DELTA+2 (cycle 78 at defaults).
- busy is high from cycle 1 through the FIN cycle inclusive.
- Accumulators hold their values in IDLE after completion. They are cleared only by start or rst.
- A start arriving in the same cycle as FIN is ignored. A start in the first IDLE cycle after FIN is accepted, so back-to-back runs are possible.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- All-zero codeword, start pulse -> cw_addr sequence 45..0. 30 syn_valid cycles, all syn_out=0x00, syn_index 0..29. done in cycle 78; no_error=1; busy low in cycle 79.
- r_0=0x01, all other bytes 0 -> every syndrome 0x01; no_error=0.
- r_1=0x01, others 0 -> S_j = alpha^j: S1=0x02, S2=0x04, S8=0x1D, S9=0x3A, S10=0x74.
- r_2=0x01, others 0 -> S1=0x04, S4=0x1D. Then run a second start immediately after done with an all-zero codeword -> all syndromes 0x00, no_error=1 (accumulators cleared by start).
- start re-pulsed during LOAD and during OUT -> ignored; address sequence, syndromes and done timing identical to a single-start run.
- rst asserted mid-LOAD (cycle 20) -> next cycle: busy=0, cw_rd_en=0, syn_valid=0, done=0, no_error=0. A fresh start with r_1=0x01 then yields S1=0x02 with done at cycle 78.
